// File: rtl/decode_stage_if.sv
// Bundle of the decode-stage pipeline signals: D-side instruction/PC, the
// writeback port, the flush control and the registered E-side outputs.
interface decode_stage_if;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RDW;
    logic [31:0] ResultW;
    logic        FlushE;

    logic        RegWrite_E;
    logic        ALUSrc_E;
    logic        MemWrite_E;
    logic        ResultSrc_E;
    logic        Branch_E;
    logic [2:0]  ALUControl_E;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] ImmExt_E;
    logic [4:0]  RD_E;
    logic [4:0]  RS1_E;
    logic [4:0]  RS2_E;
    logic [31:0] PC_E;
    logic [31:0] PCPlus4_E;

    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        input  RegWrite_E, ALUSrc_E, MemWrite_E, ResultSrc_E, Branch_E,
               ALUControl_E, RD1_E, RD2_E, ImmExt_E, RD_E, RS1_E, RS2_E,
               PC_E, PCPlus4_E
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
        output RegWrite_E, ALUSrc_E, MemWrite_E, ResultSrc_E, Branch_E,
               ALUControl_E, RD1_E, RD2_E, ImmExt_E, RD_E, RS1_E, RS2_E,
               PC_E, PCPlus4_E
    );
endinterface

// File: rtl/decode_stage.sv
// RV32 decode stage: register file with write-to-read bypass, main/ALU
// decoders, immediate generator and the flushable D->E pipeline register.
module decode_stage (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_B} imm_t;

    logic [31:0] regs [32];
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rd1, rd2, imm_ext;
    logic        reg_write, alu_src, mem_write, result_src, branch;
    logic [1:0]  alu_op;
    logic [2:0]  alu_control;
    imm_t        imm_src;
    logic        wb_en;

    assign opcode = bus.InstrD[6:0];
    assign rd     = bus.InstrD[11:7];
    assign funct3 = bus.InstrD[14:12];
    assign rs1    = bus.InstrD[19:15];
    assign rs2    = bus.InstrD[24:20];
    assign wb_en  = bus.RegWriteW && (bus.RDW != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (wb_en) begin
            regs[bus.RDW] <= bus.ResultW;
        end
    end

    // Writeback in the same cycle is forwarded so the E register never sees stale data.
    always_comb begin
        rd1 = 32'd0;
        rd2 = 32'd0;
        if (rs1 != 5'd0) rd1 = (wb_en && bus.RDW == rs1) ? bus.ResultW : regs[rs1];
        if (rs2 != 5'd0) rd2 = (wb_en && bus.RDW == rs2) ? bus.ResultW : regs[rs2];
    end

    always_comb begin
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        result_src = 1'b0;
        branch     = 1'b0;
        alu_op     = 2'b00;
        imm_src    = IMM_NONE;
        case (opcode)
            7'b0000011: begin reg_write = 1'b1; imm_src = IMM_I; alu_src = 1'b1; result_src = 1'b1; end
            7'b0100011: begin imm_src = IMM_S; alu_src = 1'b1; mem_write = 1'b1; end
            7'b0110011: begin reg_write = 1'b1; alu_op = 2'b10; end
            7'b0010011: begin reg_write = 1'b1; imm_src = IMM_I; alu_src = 1'b1; alu_op = 2'b10; end
            7'b1100011: begin imm_src = IMM_B; branch = 1'b1; alu_op = 2'b01; end
            default: ;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = (opcode[5] && bus.InstrD[30]) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        imm_ext = 32'd0;
        case (imm_src)
            IMM_I: imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
            IMM_S: imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
            IMM_B: imm_ext = {{20{bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                              bus.InstrD[11:8], 1'b0};
            default: imm_ext = 32'd0;
        endcase
    end

    // A flush clears the whole E bundle, not only the control bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || bus.FlushE) begin
            bus.RegWrite_E   <= 1'b0;
            bus.ALUSrc_E     <= 1'b0;
            bus.MemWrite_E   <= 1'b0;
            bus.ResultSrc_E  <= 1'b0;
            bus.Branch_E     <= 1'b0;
            bus.ALUControl_E <= 3'b000;
            bus.RD1_E        <= 32'd0;
            bus.RD2_E        <= 32'd0;
            bus.ImmExt_E     <= 32'd0;
            bus.RD_E         <= 5'd0;
            bus.RS1_E        <= 5'd0;
            bus.RS2_E        <= 5'd0;
            bus.PC_E         <= 32'd0;
            bus.PCPlus4_E    <= 32'd0;
        end else begin
            bus.RegWrite_E   <= reg_write;
            bus.ALUSrc_E     <= alu_src;
            bus.MemWrite_E   <= mem_write;
            bus.ResultSrc_E  <= result_src;
            bus.Branch_E     <= branch;
            bus.ALUControl_E <= alu_control;
            bus.RD1_E        <= rd1;
            bus.RD2_E        <= rd2;
            bus.ImmExt_E     <= imm_ext;
            bus.RD_E         <= rd;
            bus.RS1_E        <= rs1;
            bus.RS2_E        <= rs2;
            bus.PC_E         <= bus.PCD;
            bus.PCPlus4_E    <= bus.PCPlus4D;
        end
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-002 Port rst, input, 1: reset, asynchronous, active-low.
REQ-003 Port InstrD, input, 32: instruction from the fetch/decode register.
REQ-004 Ports PCD and PCPlus4D, input, 32 each: PC and PC+4 of InstrD.
REQ-005 Ports RegWriteW (1), RDW (5) and ResultW (32), input: writeback port.
REQ-006 Port FlushE, input, 1: insert a bubble into the E register.
REQ-007 Ports RegWrite_E, ALUSrc_E, MemWrite_E, ResultSrc_E and Branch_E, output, 1 each: registered control.
REQ-008 Port ALUControl_E, output, 3: registered ALU operation.
REQ-009 Ports RD1_E, RD2_E and ImmExt_E, output, 32 each: registered operands and immediate.
REQ-010 Ports RD_E, RS1_E and RS2_E, output, 5 each: registered register indices for the hazard unit.
REQ-011 Ports PC_E and PCPlus4_E, output, 32 each: registered PC values.

Function
REQ-012 The block SHALL contain a 32x32 register file: two combinational read ports (rs1=InstrD[19:15], rs2=InstrD[24:20]) and one write port.
REQ-013 The register file SHALL write ResultW to RDW on the rising clk edge when RegWriteW=1 and RDW!=0.
REQ-014 Register x0 SHALL always read as 0, and writes to x0 SHALL be ignored.
REQ-015 A read SHALL return ResultW when RegWriteW=1, RDW equals the read index and the index is not 0; this is a same-cycle write-to-read bypass.
REQ-016 The main decoder SHALL produce the following on opcode InstrD[6:0] (RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp):
- 0000011 lw: 1, I, 1, 0, 1, 0, 00
- 0100011 sw: 0, S, 1, 1, 0, 0, 00
- 0110011 R-type: 1, -, 0, 0, 0, 0, 10
- 0010011 I-ALU: 1, I, 1, 0, 0, 0, 10
- 1100011 beq: 0, B, 0, 0, 0, 1, 01
- any other opcode: all 0.
REQ-017 The ALU decoder SHALL map ALUOp and funct3 to ALUControl as follows:
- ALUOp 00 -> 000 (add)
- ALUOp 01 -> 001 (sub)
- ALUOp 10, funct3 000 -> 001 if opcode[5]=1 and InstrD[30]=1, else 000
- ALUOp 10, funct3 010 -> 101 (slt)
- ALUOp 10, funct3 110 -> 011 (or)
- ALUOp 10, funct3 111 -> 010 (and)
- any other combination -> 000.
REQ-018 The immediate SHALL be formed with the sign taken from InstrD[31]:
- I-type: sext(InstrD[31:20])
- S-type: sext({InstrD[31:25], InstrD[11:7]})
- B-type: sext({InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0})
- otherwise: 0.
REQ-019 Every E output SHALL be registered on each rising clk edge from the decoded values of the current cycle, giving 1-cycle latency from InstrD to the E outputs.
REQ-020 When FlushE=1 at a clock edge, RegWrite_E, MemWrite_E, Branch_E, ResultSrc_E and ALUSrc_E SHALL load 0 and ALUControl_E SHALL load 000.
REQ-021 During a flush, the remaining E outputs SHALL load 0.
REQ-022 When FlushE=1 coincides with a register-file write, the write SHALL still complete.
REQ-023 Instruction fields SHALL be decoded only from InstrD; the block SHALL hold no other state.

Reset
REQ-024 While rst=0, all E outputs SHALL be 0 and all 32 register-file entries SHALL be 0, asynchronously and independent of clk.
REQ-025 Reset asserted mid-operation SHALL discard any pending write in the same cycle.
REQ-026 After rst rises, the first rising edge SHALL capture normal decode.

Verification
REQ-027 Reset scenario: hold rst=0, then read every output and register -> all read 0; RegWriteW=1 during reset leaves the register file at 0.
REQ-028 addi scenario: InstrD=0x00500093 (addi x1,x0,5) -> next edge gives RegWrite_E=1, ALUSrc_E=1, ImmExt_E=5, RD_E=1, ALUControl_E=000, RD1_E=0.
REQ-029 Bypass scenario: RegWriteW=1, RDW=1, ResultW=0x11 in the same cycle as InstrD=0x402081B3 (sub x3,x1,x2) -> RD1_E=0x11, ALUControl_E=001, RS1_E=1, RS2_E=2, RD_E=3.
REQ-030 beq scenario: InstrD=0xFE208CE3 (beq x1,x2,-8) -> Branch_E=1, RegWrite_E=0, ImmExt_E=0xFFFFFFF8, ALUControl_E=001.
REQ-031 x0 and flush scenario: write RDW=0 with ResultW=0xDEAD, then decode lw x5,8(x0) -> RD1_E=0; the same instruction with FlushE=1 -> all control outputs 0.
REQ-032 lw scenario: InstrD=0x0080A283 (lw x5,8(x1)) with x1=0x100 -> ResultSrc_E=1, ImmExt_E=8, RD1_E=0x100, MemWrite_E=0.
